// File: rtl/ipsxe_floating_point_pkg.sv
// Shared constants and helpers for the floating-point normalisation blocks.
package ipsxe_floating_point_pkg;

   localparam int unsigned LOD_DW      = 64;
   localparam int unsigned LOD_IDX_W   = 6;
   localparam int unsigned MAX_NUM_REQ = 8;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) begin
         res++;
      end
      return res;
   endfunction

endpackage

// File: rtl/ipsxe_floating_point_lod_sched_v1_0_if.sv
// Request/response bundle between normalisation lanes and the shared LOD scheduler.
interface ipsxe_floating_point_lod_sched_v1_0_if #(
   parameter int unsigned NUM_REQ = 4
) ();
   import ipsxe_floating_point_pkg::*;

   localparam int unsigned ID_W = clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*LOD_DW-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [LOD_IDX_W-1:0]      rsp_index;
   logic                      rsp_zero;
   logic                      busy;

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      output rsp_valid,
      input  rsp_ready,
      output rsp_id,
      output rsp_index,
      output rsp_zero,
      output busy
   );

   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      input  rsp_valid,
      output rsp_ready,
      input  rsp_id,
      input  rsp_index,
      input  rsp_zero,
      input  busy
   );

endinterface

// File: rtl/ipsxe_floating_point_find_one_64bit_v1_0.sv
// Pipelined 64-bit leading-one detector; LATENCY register stages after the priority search.
module ipsxe_floating_point_find_one_64bit_v1_0
   import ipsxe_floating_point_pkg::*;
#(
   parameter int unsigned LATENCY = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_clken,
   input  logic [LOD_DW-1:0]    i_data,
   output logic [LOD_IDX_W-1:0] o_index
);

   logic [LOD_IDX_W-1:0] idx_comb;

   // Highest set bit wins; an all-zero word yields 0.
   always_comb begin
      idx_comb = '0;
      for (int unsigned b = 0; b < LOD_DW; b++) begin
         if (i_data[b]) begin
            idx_comb = LOD_IDX_W'(b);
         end
      end
   end

   if (LATENCY == 0) begin : g_comb
      assign o_index = idx_comb;
   end else begin : g_pipe
      logic [LOD_IDX_W-1:0] idx_q [LATENCY];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int unsigned s = 0; s < LATENCY; s++) begin
               idx_q[s] <= '0;
            end
         end else if (i_clken) begin
            idx_q[0] <= idx_comb;
            for (int unsigned s = 1; s < LATENCY; s++) begin
               idx_q[s] <= idx_q[s-1];
            end
         end
      end

      assign o_index = idx_q[LATENCY-1];
   end

endmodule

// File: rtl/ipsxe_floating_point_lod_sched_v1_0.sv
// Round-robin scheduler sharing one pipelined leading-one detector among NUM_REQ lanes,
// with a tag pipe tracking requester ID and zero flag alongside the detector.
module ipsxe_floating_point_lod_sched_v1_0
   import ipsxe_floating_point_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned LATENCY = 4
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic                                  i_clken,
   ipsxe_floating_point_lod_sched_v1_0_if.slave  bus
);

   localparam int unsigned ID_W = clog2(NUM_REQ);

   logic                 adv;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W:0]        cand;
   logic                 gnt_found;
   logic [ID_W-1:0]      gnt_id;
   logic                 accept;
   logic [LOD_DW-1:0]    det_in;
   logic                 in_zero;
   logic [LOD_IDX_W-1:0] det_index;

   logic                 tail_vld;
   logic [ID_W-1:0]      tail_id;
   logic                 tail_zero;
   logic                 pipe_busy;

   logic                 rsp_valid_q;
   logic [ID_W-1:0]      rsp_id_q;
   logic                 rsp_zero_q;
   logic [LOD_IDX_W-1:0] rsp_index_q;

   assign adv = i_clken & (~rsp_valid_q | bus.rsp_ready);

   // Rotating search starting at ptr_q, first valid requester wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!gnt_found && bus.req_valid[cand[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_id    = cand[ID_W-1:0];
         end
      end
   end

   assign accept        = gnt_found & adv;
   assign bus.req_ready = accept ? (NUM_REQ'(1) << gnt_id) : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      det_in = '0;
      if (accept) begin
         det_in = bus.req_data[int'(gnt_id)*LOD_DW +: LOD_DW];
      end
   end

   assign in_zero = ~|det_in;

   ipsxe_floating_point_find_one_64bit_v1_0 #(
      .LATENCY (LATENCY)
   ) u_find_one (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clken (adv),
      .i_data  (det_in),
      .o_index (det_index)
   );

   if (LATENCY == 0) begin : g_no_pipe
      assign tail_vld  = accept;
      assign tail_id   = gnt_id;
      assign tail_zero = in_zero;
      assign pipe_busy = 1'b0;
   end else begin : g_tag_pipe
      logic [LATENCY-1:0] vld_q;
      logic [LATENCY-1:0] zero_q;
      logic [ID_W-1:0]    id_q [LATENCY];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            vld_q  <= '0;
            zero_q <= '0;
            for (int unsigned s = 0; s < LATENCY; s++) begin
               id_q[s] <= '0;
            end
         end else if (adv) begin
            vld_q[0]  <= accept;
            zero_q[0] <= in_zero;
            id_q[0]   <= gnt_id;
            for (int unsigned s = 1; s < LATENCY; s++) begin
               vld_q[s]  <= vld_q[s-1];
               zero_q[s] <= zero_q[s-1];
               id_q[s]   <= id_q[s-1];
            end
         end
      end

      assign tail_vld  = vld_q[LATENCY-1];
      assign tail_id   = id_q[LATENCY-1];
      assign tail_zero = zero_q[LATENCY-1];
      assign pipe_busy = |vld_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_index_q <= '0;
      end else if (adv) begin
         rsp_valid_q <= tail_vld;
         rsp_id_q    <= tail_id;
         rsp_zero_q  <= tail_zero;
         rsp_index_q <= tail_zero ? '0 : det_index;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.rsp_index = rsp_index_q;
   assign bus.busy      = rsp_valid_q | pipe_busy;

endmodule

// File: tb/tb_ipsxe_floating_point_lod_sched_v1_0.sv
// Directed bench: LATENCY=4 instance (a) and LATENCY=0 instance (b) share the same stimulus.
module tb_ipsxe_floating_point_lod_sched_v1_0;

   logic clk;
   logic rst_n;
   logic clken;
   int   n_tests;
   int   n_fail;
   int   stale;

   logic [5:0] idx_of [4];

   ipsxe_floating_point_lod_sched_v1_0_if #(.NUM_REQ(4)) busa ();
   ipsxe_floating_point_lod_sched_v1_0_if #(.NUM_REQ(4)) busb ();

   assign busb.req_valid = busa.req_valid;
   assign busb.req_data  = busa.req_data;
   assign busb.rsp_ready = busa.rsp_ready;

   ipsxe_floating_point_lod_sched_v1_0 #(
      .NUM_REQ (4),
      .LATENCY (4)
   ) u_dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clken (clken),
      .bus     (busa)
   );

   ipsxe_floating_point_lod_sched_v1_0 #(
      .NUM_REQ (4),
      .LATENCY (0)
   ) u_dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clken (clken),
      .bus     (busb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] er(input logic v, input logic [1:0] id, input logic z,
                                      input logic [5:0] idx);
      return 64'({v, id, z, idx});
   endfunction

   function automatic logic [63:0] rsp_a();
      return 64'({busa.rsp_valid, busa.rsp_id, busa.rsp_zero, busa.rsp_index});
   endfunction

   function automatic logic [63:0] rsp_b();
      return 64'({busb.rsp_valid, busb.rsp_id, busb.rsp_zero, busb.rsp_index});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      clken          = 1'b1;
      busa.req_valid = '0;
      busa.rsp_ready = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Requester r carries a single set bit at 10*r+5.
   task automatic load_spread();
      for (int r = 0; r < 4; r++) begin
         busa.req_data[64*r +: 64] = 64'd1 << (10*r + 5);
         idx_of[r] = 6'(10*r + 5);
      end
   endtask

   initial begin
      n_tests        = 0;
      n_fail         = 0;
      busa.req_data  = '0;
      do_reset();

      check("reset_a", rsp_a(), 64'd0);
      check("reset_busy_a", 64'(busa.busy), 64'd0);
      check("reset_b", rsp_b(), 64'd0);

      // Single word, index 32
      busa.req_data[63:0] = 64'h0000_0001_0000_0000;
      busa.req_valid      = 4'b0001;
      #1;
      check("t1_gnt_a", 64'(busa.req_ready), 64'h1);
      check("t1_gnt_b", 64'(busb.req_ready), 64'h1);
      step();
      busa.req_valid = '0;
      check("t1_rsp_b", rsp_b(), er(1'b1, 2'd0, 1'b0, 6'd32));
      step(); step(); step();
      check("t1_early_a", 64'(busa.rsp_valid), 64'd0);
      step();
      check("t1_rsp_a", rsp_a(), er(1'b1, 2'd0, 1'b0, 6'd32));
      step();
      check("t1_done_a", 64'(busa.rsp_valid), 64'd0);

      // Round-robin with all four requesting
      do_reset();
      load_spread();
      busa.req_valid = 4'b1111;
      for (int k = 0; k < 10; k++) begin
         if (k < 5) begin
            #1;
            check($sformatf("t2_gnt_a%0d", k), 64'(busa.req_ready), 64'd1 << (k % 4));
            check($sformatf("t2_gnt_b%0d", k), 64'(busb.req_ready), 64'd1 << (k % 4));
         end
         step();
         if (k == 4) busa.req_valid = '0;
         if (k < 5)
            check($sformatf("t2_rsp_b%0d", k), rsp_b(),
                  er(1'b1, 2'(k % 4), 1'b0, idx_of[k % 4]));
         if (k >= 4 && k < 9)
            check($sformatf("t2_rsp_a%0d", k - 4), rsp_a(),
                  er(1'b1, 2'((k - 4) % 4), 1'b0, idx_of[(k - 4) % 4]));
      end

      // Zero word from req2, then word 1 from req1 (ptr wraps 3 -> 0 -> 1)
      do_reset();
      busa.req_data          = '0;
      busa.req_data[64 +: 64] = 64'h1;
      busa.req_valid         = 4'b0100;
      #1;
      check("t3_gnt2", 64'(busa.req_ready), 64'h4);
      step();
      check("t3_rsp_b2", rsp_b(), er(1'b1, 2'd2, 1'b1, 6'd0));
      busa.req_valid = 4'b0010;
      #1;
      check("t3_gnt1", 64'(busa.req_ready), 64'h2);
      step();
      busa.req_valid = '0;
      check("t3_rsp_b1", rsp_b(), er(1'b1, 2'd1, 1'b0, 6'd0));
      step(); step(); step();
      check("t3_rsp_a2", rsp_a(), er(1'b1, 2'd2, 1'b1, 6'd0));
      step();
      check("t3_rsp_a1", rsp_a(), er(1'b1, 2'd1, 1'b0, 6'd0));

      // Backpressure with the pipe full
      do_reset();
      load_spread();
      busa.req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) step();
      check("t4_first", rsp_a(), er(1'b1, 2'd0, 1'b0, idx_of[0]));
      busa.rsp_ready = 1'b0;
      #1;
      check("t4_stall_gnt", 64'(busa.req_ready), 64'd0);
      for (int s = 0; s < 3; s++) begin
         step();
         check($sformatf("t4_hold%0d", s), rsp_a(), er(1'b1, 2'd0, 1'b0, idx_of[0]));
      end
      busa.rsp_ready = 1'b1;
      busa.req_valid = '0;
      for (int j = 1; j < 5; j++) begin
         step();
         check($sformatf("t4_rsp%0d", j), rsp_a(), er(1'b1, 2'(j % 4), 1'b0, idx_of[j % 4]));
      end
      step();
      check("t4_no_dup", 64'(busa.rsp_valid), 64'd0);
      check("t4_idle", 64'(busa.busy), 64'd0);

      // Clock-enable freeze for two cycles mid-stream
      do_reset();
      busa.req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) step();
      check("t5_pre", rsp_a(), er(1'b1, 2'd1, 1'b0, idx_of[1]));
      clken = 1'b0;
      #1;
      check("t5_frz_gnt", 64'(busa.req_ready), 64'd0);
      step();
      check("t5_frz0", rsp_a(), er(1'b1, 2'd1, 1'b0, idx_of[1]));
      step();
      check("t5_frz1", rsp_a(), er(1'b1, 2'd1, 1'b0, idx_of[1]));
      check("t5_frz_busy", 64'(busa.busy), 64'd1);
      clken = 1'b1;
      for (int j = 2; j < 5; j++) begin
         step();
         check($sformatf("t5_rsp%0d", j), rsp_a(), er(1'b1, 2'(j % 4), 1'b0, idx_of[j % 4]));
      end
      busa.req_valid = '0;

      // Asynchronous reset with three words in flight
      do_reset();
      busa.req_valid = 4'b1111;
      step(); step(); step();
      busa.req_valid = '0;
      #1;
      check("t6_inflight", 64'(busa.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_a", rsp_a(), 64'd0);
      check("t6_rst_busy", 64'(busa.busy), 64'd0);
      check("t6_rst_b", rsp_b(), 64'd0);
      step();
      rst_n = 1'b1;
      stale = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (busa.rsp_valid || busa.busy) stale++;
      end
      check("t6_stale", 64'(stale), 64'd0);
      busa.req_valid = 4'b1111;
      #1;
      check("t6_ptr0", 64'(busa.req_ready), 64'h1);
      busa.req_valid = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
